mcpu_ctrl_fsm: RTL and testbench

Multi-cycle MIPS control unit. It generates the per-cycle control word (MemtoReg, RegWrite, RegDst, ALU_Control, ALUSrc, PC-write strobes, ...) that the shared Data_path consumes. It takes the latched instruction and the ALU zero flag, sequences fetch/decode/execute/memory/writeback, and stalls on a memory ready handshake. It sits between instruction/data memory and the datapath in the ExtSCPU top level.

---
 rtl/mcpu_pkg.sv | 54 +++++
 rtl/mcpu_alu_dec.sv | 24 ++
 rtl/mcpu_ctrl_fsm.sv | 200 ++++++++++++++++++++
 tb/tb_mcpu_ctrl_fsm.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcpu_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: states, opcodes,
// funct codes, ALU_Control codes and datapath mux selects.
package mcpu_pkg;

  typedef enum logic [3:0] {
    ST_IF       = 4'd0,
    ST_ID       = 4'd1,
    ST_MEM_ADDR = 4'd2,
    ST_MEM_RD   = 4'd3,
    ST_WB_LW    = 4'd4,
    ST_MEM_WR   = 4'd5,
    ST_EX_R     = 4'd6,
    ST_WB_R     = 4'd7,
    ST_BEQ      = 4'd8,
    ST_JUMP     = 4'd9,
    ST_EX_I     = 4'd10,
    ST_WB_I     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam int MEM_WAIT_MAX_DEF = 15;

endpackage

// File: rtl/mcpu_alu_dec.sv
// R-type funct to ALU_Control decoder, shared with the single-cycle controller.
module mcpu_alu_dec
  import mcpu_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_ctrl,
  output logic       funct_valid
);

  always_comb begin
    alu_ctrl    = ALU_ADD;
    funct_valid = 1'b1;
    case (funct)
      FN_ADD:  alu_ctrl = ALU_ADD;
      FN_SUB:  alu_ctrl = ALU_SUB;
      FN_AND:  alu_ctrl = ALU_AND;
      FN_OR:   alu_ctrl = ALU_OR;
      FN_NOR:  alu_ctrl = ALU_NOR;
      FN_SLT:  alu_ctrl = ALU_SLT;
      default: funct_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/mcpu_ctrl_fsm.sv
// Multi-cycle MIPS control unit with memory-ready stalls and sticky error flags.
// Build option: define MCPU_BNE_EN to execute bne through the branch state.
//
// state    | meaning
// IF       | fetch, wait for mem_ready, load IR and PC+4
// ID       | decode, branch target into ALUOut, opcode dispatch
// MEM_ADDR | lw/sw address = A + imm
// MEM_RD   | data read, wait for mem_ready
// WB_LW    | MDR to rt
// MEM_WR   | data write, wait for mem_ready
// EX_R     | R-type ALU op from funct
// WB_R     | ALUOut to rd
// BEQ      | compare A - B, conditional PC load
// JUMP     | PC <= jump target
// EX_I     | addi/slti ALU op with imm
// WB_I     | ALUOut to rt
module mcpu_ctrl_fsm
  import mcpu_pkg::*;
#(
  parameter int MEM_WAIT_MAX = MEM_WAIT_MAX_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_in,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IorD,
  output logic        IRWrite,
  output logic        RegDst,
  output logic        MemtoReg,
  output logic        RegWrite,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [2:0]  ALU_Control,
  output logic        PCWrite,
  output logic        Branch,
  output logic [1:0]  PCSource,
  output logic        illegal_op,
  output logic        mem_timeout,
  output logic [3:0]  state_out
);

  localparam int WCW = $clog2(MEM_WAIT_MAX + 1);

  state_t         state, state_nxt, dec_state;
  logic [WCW-1:0] wait_cnt;
  logic           ill_set, waiting;
  logic [5:0]     opcode;
  logic [2:0]     r_alu_ctrl;
  logic           r_funct_valid;
  logic           unused_ok;

  assign opcode    = inst_in[31:26];
  assign state_out = state;
  assign unused_ok = ^{inst_in[25:6], zero};
  // While rst is held the control word is decoded as IF with no strobes.
  assign dec_state = rst ? ST_IF : state;
  assign waiting   = (state == ST_IF || state == ST_MEM_RD || state == ST_MEM_WR)
                     && !mem_ready;

  mcpu_alu_dec u_alu_dec (
    .funct       (inst_in[5:0]),
    .alu_ctrl    (r_alu_ctrl),
    .funct_valid (r_funct_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IF;
      illegal_op  <= 1'b0;
      mem_timeout <= 1'b0;
      wait_cnt    <= WCW'(MEM_WAIT_MAX);
    end else begin
      state <= state_nxt;
      if (ill_set) illegal_op <= 1'b1;
      if (waiting) begin
        if (wait_cnt != '0) wait_cnt <= wait_cnt - WCW'(1);
        if (wait_cnt == WCW'(1)) mem_timeout <= 1'b1;
      end else begin
        wait_cnt <= WCW'(MEM_WAIT_MAX);
      end
    end
  end

  always_comb begin
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IorD        = 1'b0;
    IRWrite     = 1'b0;
    RegDst      = 1'b0;
    MemtoReg    = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_REG;
    ALU_Control = ALU_AND;
    PCWrite     = 1'b0;
    Branch      = 1'b0;
    PCSource    = PCSRC_ALU;
    ill_set     = 1'b0;
    state_nxt   = state;
    case (dec_state)
      ST_IF: begin
        MemRead     = 1'b1;
        ALUSrcB     = SRCB_FOUR;
        ALU_Control = ALU_ADD;
        if (mem_ready) begin
          IRWrite   = !rst;
          PCWrite   = !rst;
          state_nxt = ST_ID;
        end
      end
      ST_ID: begin
        ALUSrcB     = SRCB_IMM_SH2;
        ALU_Control = ALU_ADD;
        case (opcode)
          OP_RTYPE:          state_nxt = ST_EX_R;
          OP_LW, OP_SW:      state_nxt = ST_MEM_ADDR;
          OP_BEQ:            state_nxt = ST_BEQ;
`ifdef MCPU_BNE_EN
          OP_BNE:            state_nxt = ST_BEQ;
`endif
          OP_J:              state_nxt = ST_JUMP;
          OP_ADDI, OP_SLTI:  state_nxt = ST_EX_I;
          default: begin
            ill_set   = 1'b1;
            state_nxt = ST_IF;
          end
        endcase
      end
      ST_EX_R: begin
        ALUSrcA     = 1'b1;
        ALU_Control = r_alu_ctrl;
        if (r_funct_valid) begin
          state_nxt = ST_WB_R;
        end else begin
          ill_set   = 1'b1;
          state_nxt = ST_IF;
        end
      end
      ST_WB_R: begin
        RegDst    = 1'b1;
        RegWrite  = 1'b1;
        state_nxt = ST_IF;
      end
      ST_MEM_ADDR: begin
        ALUSrcA     = 1'b1;
        ALUSrcB     = SRCB_IMM;
        ALU_Control = ALU_ADD;
        state_nxt   = (opcode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
      end
      ST_MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready) state_nxt = ST_WB_LW;
      end
      ST_WB_LW: begin
        MemtoReg  = 1'b1;
        RegWrite  = 1'b1;
        state_nxt = ST_IF;
      end
      ST_MEM_WR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (mem_ready) state_nxt = ST_IF;
      end
      ST_BEQ: begin
        ALUSrcA     = 1'b1;
        ALU_Control = ALU_SUB;
        PCSource    = PCSRC_ALUOUT;
`ifdef MCPU_BNE_EN
        // bne shares the compare but loads the PC on inequality.
        if (opcode == OP_BNE) PCWrite = ~zero;
        else                  Branch  = 1'b1;
`else
        Branch      = 1'b1;
`endif
        state_nxt   = ST_IF;
      end
      ST_JUMP: begin
        PCWrite   = 1'b1;
        PCSource  = PCSRC_JUMP;
        state_nxt = ST_IF;
      end
      ST_EX_I: begin
        ALUSrcA     = 1'b1;
        ALUSrcB     = SRCB_IMM;
        ALU_Control = (opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
        state_nxt   = ST_WB_I;
      end
      ST_WB_I: begin
        RegWrite  = 1'b1;
        state_nxt = ST_IF;
      end
      default: state_nxt = ST_IF;
    endcase
  end

endmodule

// File: tb/tb_mcpu_ctrl_fsm.sv
// Bench for mcpu_ctrl_fsm: queue-based instruction-path model checked every cycle,
// plus directed latency/flag checks; honours MCPU_BNE_EN.
module tb_mcpu_ctrl_fsm;

  localparam int S_IF = 0, S_ID = 1, S_MA = 2, S_MRD = 3, S_WBLW = 4, S_MWR = 5,
                 S_EXR = 6, S_WBR = 7, S_BEQ = 8, S_J = 9, S_EXI = 10, S_WBI = 11;
`ifdef MCPU_BNE_EN
  localparam bit BNE_ON = 1'b1;
`else
  localparam bit BNE_ON = 1'b0;
`endif

  logic        clk = 1'b0, rst = 1'b1, zero = 1'b0, mem_ready = 1'b1;
  logic [31:0] inst_in = '0;
  logic        MemRead, MemWrite, IorD, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0]  ALUSrcB, PCSource;
  logic [2:0]  ALU_Control;
  logic        PCWrite, Branch, illegal_op, mem_timeout;
  logic [3:0]  state_out;

  mcpu_ctrl_fsm dut (
    .clk(clk), .rst(rst), .inst_in(inst_in), .zero(zero), .mem_ready(mem_ready),
    .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALU_Control(ALU_Control), .PCWrite(PCWrite), .Branch(Branch),
    .PCSource(PCSource), .illegal_op(illegal_op), .mem_timeout(mem_timeout),
    .state_out(state_out)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  int   path[$];
  int   m_cur = S_IF;
  int   m_wait = 0;
  int   popped;
  bit   m_ill = 1'b0, m_to = 1'b0, m_valid = 1'b0;
  logic [5:0] op;

  function automatic bit funct_ok(input logic [5:0] f);
    return f inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
  endfunction

  function automatic logic [2:0] alu_of(input logic [5:0] f);
    case (f)
      6'h20: return 3'b010;
      6'h22: return 3'b110;
      6'h24: return 3'b000;
      6'h25: return 3'b001;
      6'h27: return 3'b100;
      6'h2A: return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

  // Control word expected for a step of the instruction path.
  function automatic logic [22:0] exp_cw(input int st, input logic [31:0] ins,
                                         input logic mr, input logic z, input logic r,
                                         input bit ill, input bit to);
    logic mrd = 0, mwr = 0, iord = 0, irw = 0, rdst = 0, m2r = 0, rw = 0, asa = 0;
    logic pcw = 0, br = 0;
    logic [1:0] asb = 0, pcs = 0;
    logic [2:0] alu = 0;
    case (r ? S_IF : st)
      S_IF:   begin mrd = 1; asb = 2'b01; alu = 3'b010; irw = mr & !r; pcw = mr & !r; end
      S_ID:   begin asb = 2'b11; alu = 3'b010; end
      S_EXR:  begin asa = 1; alu = alu_of(ins[5:0]); end
      S_WBR:  begin rdst = 1; rw = 1; end
      S_MA:   begin asa = 1; asb = 2'b10; alu = 3'b010; end
      S_MRD:  begin mrd = 1; iord = 1; end
      S_WBLW: begin m2r = 1; rw = 1; end
      S_MWR:  begin mwr = 1; iord = 1; end
      S_BEQ:  begin
        asa = 1; alu = 3'b110; pcs = 2'b01;
        if (BNE_ON && ins[31:26] == 6'b000101) pcw = ~z;
        else br = 1;
      end
      S_J:    begin pcw = 1; pcs = 2'b10; end
      S_EXI:  begin asa = 1; asb = 2'b10; alu = (ins[31:26] == 6'b001010) ? 3'b111 : 3'b010; end
      S_WBI:  begin rw = 1; end
      default: ;
    endcase
    return {mrd, mwr, iord, irw, rdst, m2r, rw, asa, asb, alu, pcw, br, pcs, ill, to, 4'(st)};
  endfunction

  // Model: the instruction is a queue of steps; ID expands it from the opcode.
  always @(posedge clk) begin
    if (rst) begin
      path = '{S_IF, S_ID};
      m_ill = 0; m_to = 0; m_wait = 0; m_valid = 1;
    end else if (m_valid) begin
      if ((path[0] == S_IF || path[0] == S_MRD || path[0] == S_MWR) && !mem_ready) begin
        m_wait++;
        if (m_wait == 15) m_to = 1;
      end else begin
        m_wait = 0;
        popped = path.pop_front();
        if (popped == S_ID) begin
          op = inst_in[31:26];
          case (op)
            6'h00: begin path.push_back(S_EXR); if (funct_ok(inst_in[5:0])) path.push_back(S_WBR); end
            6'h23: begin path.push_back(S_MA); path.push_back(S_MRD); path.push_back(S_WBLW); end
            6'h2B: begin path.push_back(S_MA); path.push_back(S_MWR); end
            6'h04: path.push_back(S_BEQ);
            6'h05: if (BNE_ON) path.push_back(S_BEQ); else m_ill = 1;
            6'h02: path.push_back(S_J);
            6'h08, 6'h0A: begin path.push_back(S_EXI); path.push_back(S_WBI); end
            default: m_ill = 1;
          endcase
          path.push_back(S_IF);
          path.push_back(S_ID);
        end else if (popped == S_EXR && !funct_ok(inst_in[5:0])) begin
          m_ill = 1;
        end
      end
    end
    m_cur = path[0];
  end

  logic [22:0] got_cw, exp_v, mask_v;
  always @(negedge clk) begin
    if (m_valid) begin
      got_cw = {MemRead, MemWrite, IorD, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                ALUSrcB, ALU_Control, PCWrite, Branch, PCSource, illegal_op, mem_timeout,
                state_out};
      exp_v  = exp_cw(m_cur, inst_in, mem_ready, zero, rst, m_ill, m_to);
      mask_v = '1;
      if (!rst && m_cur == S_EXR && !funct_ok(inst_in[5:0])) mask_v[12:10] = 3'b000;
      total++;
      if ((got_cw & mask_v) !== (exp_v & mask_v)) begin
        bad++;
        $display("FAIL cw t=%0t step=%0d inst=%h got=%h exp=%h", $time, m_cur, inst_in,
                 got_cw, exp_v);
      end
    end
  end

  task automatic chk(input string nm, input int got, input int expv);
    total++;
    if (got != expv) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, expv);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Runs one instruction from IF; stalls the data phase for 'waits' cycles.
  task automatic run_chk(input string nm, input logic [31:0] ins, input int waits,
                         input logic z, input int ecyc, input int erd, input int epcw);
    int cyc = 0, rd = 0, pcw = 0, left = waits;
    bit done = 0;
    inst_in = ins;
    zero    = z;
    while (!done && cyc < 40) begin
      mem_ready = ((m_cur == S_MRD || m_cur == S_MWR) && left > 0) ? 1'b0 : 1'b1;
      if (!mem_ready) left--;
      @(negedge clk);
      if (MemRead && IorD) rd++;
      if (PCWrite && state_out != 4'd0) pcw++;
      @(posedge clk); #1;
      cyc++;
      if (state_out == 4'd0) done = 1;
    end
    chk({nm, "_cycles"}, cyc, ecyc);
    chk({nm, "_memrd"}, rd, erd);
    chk({nm, "_pcw"}, pcw, epcw);
  endtask

  function automatic logic [31:0] rand_inst();
    logic [5:0] fl [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
    logic [31:0] ins = $urandom;
    case ($urandom_range(0, 9))
      0: begin ins[31:26] = 6'h00; ins[5:0] = fl[$urandom_range(0, 5)]; end
      1: ins[31:26] = 6'h00;
      2: ins[31:26] = 6'h23;
      3: ins[31:26] = 6'h2B;
      4: ins[31:26] = 6'h04;
      5: ins[31:26] = 6'h05;
      6: ins[31:26] = 6'h02;
      7: ins[31:26] = 6'h08;
      8: ins[31:26] = 6'h0A;
      default: ;
    endcase
    return ins;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int burst = 0;
    bit hit = 0;
    rst = 1'b1;
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_state", state_out, 0);
    chk("rst_memread", MemRead, 1);
    chk("rst_irwrite", IRWrite, 0);
    chk("rst_pcwrite", PCWrite, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_chk("add",  32'h00A00820, 0, 1'b0, 4, 0, 0);
    run_chk("lw",   32'h8C05000E, 3, 1'b0, 8, 4, 0);
    run_chk("beq",  32'h10A2FFFB, 0, 1'b1, 3, 0, 0);
    run_chk("j",    32'h08000000, 0, 1'b0, 3, 0, 1);
    run_chk("sw",   32'hAC05000E, 1, 1'b0, 5, 0, 0);
    chk("ill_clear", illegal_op, 0);
    run_chk("op3f", 32'hFC000000, 0, 1'b0, 2, 0, 0);
    chk("ill_op", illegal_op, 1);
    do_reset();
    run_chk("badfn", 32'h00A00821, 0, 1'b0, 3, 0, 0);
    chk("ill_funct", illegal_op, 1);
    do_reset();
    run_chk("bne",  32'h14A2FFFB, 0, 1'b0, BNE_ON ? 3 : 2, 0, BNE_ON ? 1 : 0);
    chk("bne_ill", illegal_op, BNE_ON ? 0 : 1);

    do_reset();
    mem_ready = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 15) chk("to_pre", mem_timeout, 0);
      if (k == 16) chk("to_post", mem_timeout, 1);
      @(posedge clk); #1;
    end

    inst_in   = 32'hAC05000E;
    mem_ready = 1'b1;
    for (int k = 0; k < 10 && !hit; k++) begin
      @(posedge clk); #1;
      if (m_cur == S_MWR) hit = 1;
    end
    chk("reach_memwr", int'(hit), 1);
    mem_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_memwrite", MemWrite, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_state_mid", state_out, 0);
    chk("rst_timeout", mem_timeout, 0);
    chk("rst_illegal", illegal_op, 0);

    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      if (burst > 0) begin
        mem_ready = 1'b0;
        burst--;
      end else begin
        mem_ready = ($urandom_range(0, 9) < 7);
        if ($urandom_range(0, 299) == 0) burst = 20;
      end
      zero = 1'($urandom);
      if (m_cur == S_IF) inst_in = rand_inst();
      @(posedge clk); #1;
    end
    rst = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
